// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle for the ex_muldiv execute stage: ID/EX inputs and EX/MEM write ports.
interface ex_muldiv_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) ();
    logic                  valid_i;
    logic [3:0]            op_i;
    logic [DATA_W-1:0]     rdata1_i;
    logic [DATA_W-1:0]     rdata2_i;
    logic [REG_ADDR_W-1:0] rw_i;
    logic                  wreg_i;
    logic                  cancel_i;
    logic [REG_ADDR_W-1:0] rw_o;
    logic                  wreg_o;
    logic [DATA_W-1:0]     wdata_o;
    logic                  whilo_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  ovf_o;
    logic                  stall_o;

    modport master (
        output valid_i, op_i, rdata1_i, rdata2_i, rw_i, wreg_i, cancel_i,
        input  rw_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, ovf_o, stall_o
    );

    modport slave (
        input  valid_i, op_i, rdata1_i, rdata2_i, rw_i, wreg_i, cancel_i,
        output rw_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, ovf_o, stall_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle ALU/multiply plus an iterative radix-2 restoring divider
// that holds the pipeline through stall_o while busy.
module ex_muldiv #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input logic         clk,
    input logic         rst,
    ex_muldiv_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned MSB    = DATA_W - 1;

    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_ADDU  = 4'd6;
    localparam logic [3:0] OP_SUB   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              live;
    logic              is_div;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_abs;
    logic [DATA_W-1:0] b_abs;

    assign a      = bus.rdata1_i;
    assign b      = bus.rdata2_i;
    assign live   = bus.valid_i & ~bus.cancel_i;
    assign is_div = (bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU);
    assign a_neg  = (bus.op_i == OP_DIV) & a[MSB];
    assign b_neg  = (bus.op_i == OP_DIV) & b[MSB];
    assign a_abs  = a_neg ? -a : a;
    assign b_abs  = b_neg ? -b : b;

    // Single-cycle datapath
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic              slt;
    logic              sltu;
    logic [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0] prod_u;

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
    assign slt     = $signed(a) < $signed(b);
    assign sltu    = a < b;
    // Low 2W bits of a product of sign-extended operands equal the signed product
    assign prod_s  = {{DATA_W{a[MSB]}}, a} * {{DATA_W{b[MSB]}}, b};
    assign prod_u  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    // One restoring shift-subtract step; quo_q shifts the dividend out and quotient bits in
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   trial_sub;
    logic              fits;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] res_quo;
    logic [DATA_W-1:0] res_rem;

    assign trial     = {rem_q, quo_q[MSB]};
    assign trial_sub = trial - {1'b0, dvs_q};
    assign fits      = ~trial_sub[DATA_W];
    assign rem_nxt   = fits ? trial_sub[DATA_W-1:0] : trial[DATA_W-1:0];
    assign res_quo   = neg_q ? -quo_q : quo_q;
    assign res_rem   = neg_r ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (live && is_div) begin
                        cnt_q <= '0;
                        if (b == '0) begin
                            state <= S_DONE;
                            quo_q <= '1;
                            rem_q <= a;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            state <= S_BUSY;
                            quo_q <= a_abs;
                            rem_q <= '0;
                            dvs_q <= b_abs;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.cancel_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= {quo_q[DATA_W-2:0], fits};
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output mux, then valid/cancel/reset gating
    always_comb begin
        bus.rw_o    = bus.rw_i;
        bus.wreg_o  = 1'b0;
        bus.wdata_o = '0;
        bus.whilo_o = 1'b0;
        bus.hi_o    = '0;
        bus.lo_o    = '0;
        bus.ovf_o   = 1'b0;
        bus.stall_o = 1'b0;

        case (state)
            S_IDLE: begin
                case (bus.op_i)
                    OP_OR:   begin bus.wdata_o = a | b;    bus.wreg_o = bus.wreg_i; end
                    OP_AND:  begin bus.wdata_o = a & b;    bus.wreg_o = bus.wreg_i; end
                    OP_XOR:  begin bus.wdata_o = a ^ b;    bus.wreg_o = bus.wreg_i; end
                    OP_NOR:  begin bus.wdata_o = ~(a | b); bus.wreg_o = bus.wreg_i; end
                    OP_ADD: begin
                        bus.wdata_o = sum;
                        bus.ovf_o   = add_ovf;
                        bus.wreg_o  = bus.wreg_i & ~add_ovf;
                    end
                    OP_ADDU: begin bus.wdata_o = sum; bus.wreg_o = bus.wreg_i; end
                    OP_SUB: begin
                        bus.wdata_o = diff;
                        bus.ovf_o   = sub_ovf;
                        bus.wreg_o  = bus.wreg_i & ~sub_ovf;
                    end
                    OP_SLT:  begin bus.wdata_o = {{(DATA_W-1){1'b0}}, slt};  bus.wreg_o = bus.wreg_i; end
                    OP_SLTU: begin bus.wdata_o = {{(DATA_W-1){1'b0}}, sltu}; bus.wreg_o = bus.wreg_i; end
                    OP_MULT: begin
                        bus.hi_o    = prod_s[PROD_W-1:DATA_W];
                        bus.lo_o    = prod_s[DATA_W-1:0];
                        bus.whilo_o = 1'b1;
                    end
                    OP_MULTU: begin
                        bus.hi_o    = prod_u[PROD_W-1:DATA_W];
                        bus.lo_o    = prod_u[DATA_W-1:0];
                        bus.whilo_o = 1'b1;
                    end
                    OP_DIV, OP_DIVU: bus.stall_o = 1'b1;
                    default: ;
                endcase
            end
            S_BUSY: bus.stall_o = 1'b1;
            S_DONE: begin
                bus.whilo_o = 1'b1;
                bus.hi_o    = res_rem;
                bus.lo_o    = res_quo;
            end
            default: ;
        endcase

        if (!live) begin
            bus.wreg_o  = 1'b0;
            bus.whilo_o = 1'b0;
            bus.ovf_o   = 1'b0;
            bus.stall_o = 1'b0;
        end

        if (rst) begin
            bus.rw_o    = '0;
            bus.wreg_o  = 1'b0;
            bus.wdata_o = '0;
            bus.whilo_o = 1'b0;
            bus.hi_o    = '0;
            bus.lo_o    = '0;
            bus.ovf_o   = 1'b0;
            bus.stall_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus randomized ops against an arithmetic model.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.DATA_W(32), .REG_ADDR_W(5)) b32 ();
    ex_muldiv_if #(.DATA_W(8),  .REG_ADDR_W(5)) b8 ();

    ex_muldiv #(.DATA_W(32), .REG_ADDR_W(5)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    ex_muldiv #(.DATA_W(8),  .REG_ADDR_W(5)) u8  (.clk(clk), .rst(rst), .bus(b8.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        b32.valid_i  = v;
        b32.op_i     = op;
        b32.rdata1_i = a;
        b32.rdata2_i = b;
        b32.cancel_i = c;
        b32.rw_i     = 5'd3;
        b32.wreg_i   = 1'b1;
    endtask

    // Arithmetic reference for single-cycle ops, 32-bit
    function automatic void model_single(input int op, input logic [31:0] a, input logic [31:0] b,
                                         input logic wr_in, output logic [31:0] wd,
                                         output logic wr, output logic ovf, output logic whilo,
                                         output logic [31:0] hi, output logic [31:0] lo);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      s;
        longint      p;
        logic [63:0] pu;
        wd = '0; wr = 1'b0; ovf = 1'b0; whilo = 1'b0; hi = '0; lo = '0;
        case (op)
            1: begin wd = a | b;    wr = wr_in; end
            2: begin wd = a & b;    wr = wr_in; end
            3: begin wd = a ^ b;    wr = wr_in; end
            4: begin wd = ~(a | b); wr = wr_in; end
            5, 7: begin
                s   = (op == 5) ? sa + sb : sa - sb;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                wd  = s[31:0];
                wr  = wr_in && !ovf;
            end
            6: begin wd = a + b; wr = wr_in; end
            8: begin wd = (sa < sb) ? 32'd1 : 32'd0; wr = wr_in; end
            9: begin wd = (a < b) ? 32'd1 : 32'd0;   wr = wr_in; end
            10: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; whilo = 1'b1; end
            11: begin
                pu = {32'd0, a} * {32'd0, b};
                hi = pu[63:32]; lo = pu[31:0]; whilo = 1'b1;
            end
            default: ;
        endcase
    endfunction

    // Arithmetic reference for division at width w (C-style truncating divide)
    function automatic void model_div(input logic sgn, input int w, input logic [63:0] a,
                                      input logic [63:0] b, output logic [63:0] hi,
                                      output logic [63:0] lo);
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        longint      sa, sb, q, r;
        if ((b & mask) == 64'd0) begin
            lo = mask;
            hi = a & mask;
        end else if (sgn) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            q  = sa / sb;
            r  = sa % sb;
            lo = q & mask;
            hi = r & mask;
        end else begin
            lo = ((a & mask) / (b & mask)) & mask;
            hi = ((a & mask) % (b & mask)) & mask;
        end
    endfunction

    // Issues a 32-bit divide at posedge+1, counts stall cycles, checks the result cycle
    task automatic run_div32(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int exp_stalls,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n = 0;
        drive(1'b1, op, a, b, 1'b0);
        #1;
        for (int i = 0; i < 64 && b32.stall_o === 1'b1; i++) begin
            n++;
            @(posedge clk); #2;
        end
        chk({tag, "_stalls"}, 64'(n), 64'(exp_stalls));
        chk({tag, "_whilo"},  64'(b32.whilo_o), 64'd1);
        chk({tag, "_lo"},     64'(b32.lo_o), 64'(exp_lo));
        chk({tag, "_hi"},     64'(b32.hi_o), 64'(exp_hi));
        chk({tag, "_wreg"},   64'(b32.wreg_o), 64'd0);
        @(posedge clk); #1;
        drive(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        chk({tag, "_idle_whilo"}, 64'(b32.whilo_o), 64'd0);
        chk({tag, "_idle_stall"}, 64'(b32.stall_o), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, wd, hi, lo;
        logic        wr, ovf, whilo, wr_in;
        logic [63:0] mhi, mlo;
        int          op, n;

        rst = 1'b1;
        drive(1'b1, 4'd1, 32'hFFFF_0000, 32'h0000_FF00, 1'b0);
        b8.valid_i = 1'b0; b8.op_i = 4'd0; b8.rdata1_i = '0; b8.rdata2_i = '0;
        b8.rw_i = '0; b8.wreg_i = 1'b0; b8.cancel_i = 1'b0;
        @(posedge clk); #2;
        chk("rst_wdata", 64'(b32.wdata_o), 64'd0);
        chk("rst_wreg",  64'(b32.wreg_o),  64'd0);
        chk("rst_rw",    64'(b32.rw_o),    64'd0);
        chk("rst_stall", 64'(b32.stall_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Logic and add/sub
        drive(1'b1, 4'd1, 32'h0000_F0F0, 32'h0F0F_0000, 1'b0);
        b32.rw_i = 5'd9; #1;
        chk("or_wdata", 64'(b32.wdata_o), 64'h0F0F_F0F0);
        chk("or_wreg",  64'(b32.wreg_o),  64'd1);
        chk("or_rw",    64'(b32.rw_o),    64'd9);
        b32.wreg_i = 1'b0; #1;
        chk("or_wreg_follow", 64'(b32.wreg_o), 64'd0);
        @(posedge clk); #1;
        drive(1'b1, 4'd5, 32'h7FFF_FFFF, 32'd1, 1'b0); #1;
        chk("add_ovf",  64'(b32.ovf_o),  64'd1);
        chk("add_wreg", 64'(b32.wreg_o), 64'd0);
        b32.valid_i = 1'b0; #1;
        chk("add_invalid_ovf", 64'(b32.ovf_o), 64'd0);
        @(posedge clk); #1;
        drive(1'b1, 4'd6, 32'h7FFF_FFFF, 32'd1, 1'b0); #1;
        chk("addu_wdata", 64'(b32.wdata_o), 64'h8000_0000);
        chk("addu_wreg",  64'(b32.wreg_o),  64'd1);
        chk("addu_ovf",   64'(b32.ovf_o),   64'd0);
        @(posedge clk); #1;

        // Compare and multiply
        drive(1'b1, 4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0); #1;
        chk("slt", 64'(b32.wdata_o), 64'd1);
        drive(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0); #1;
        chk("sltu", 64'(b32.wdata_o), 64'd0);
        @(posedge clk); #1;
        drive(1'b1, 4'd10, 32'hFFFF_FFFD, 32'd7, 1'b0); #1;
        chk("mult_hi",    64'(b32.hi_o),    64'hFFFF_FFFF);
        chk("mult_lo",    64'(b32.lo_o),    64'hFFFF_FFEB);
        chk("mult_whilo", 64'(b32.whilo_o), 64'd1);
        chk("mult_stall", 64'(b32.stall_o), 64'd0);
        chk("mult_wreg",  64'(b32.wreg_o),  64'd0);
        @(posedge clk); #1;

        // Divides
        run_div32("div_m7_2",  4'd12, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div32("divu_100_7", 4'd13, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_div32("divu_by0",  4'd13, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
        run_div32("div_minneg", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

        // Cancel mid-divide
        drive(1'b1, 4'd12, 32'hFFFF_FF9C, 32'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        b32.cancel_i = 1'b1; #1;
        chk("cancel_stall", 64'(b32.stall_o), 64'd0);
        chk("cancel_whilo", 64'(b32.whilo_o), 64'd0);
        @(posedge clk); #1;
        drive(1'b1, 4'd0, 32'd0, 32'd0, 1'b0); #1;
        chk("cancel_idle_stall", 64'(b32.stall_o), 64'd0);
        chk("cancel_idle_whilo", 64'(b32.whilo_o), 64'd0);
        @(posedge clk); #1;
        run_div32("div_after_cancel", 4'd12, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Reset mid-divide
        drive(1'b1, 4'd13, 32'd12345, 32'd17, 1'b0);
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
        rst = 1'b1; #1;
        chk("rstmid_stall", 64'(b32.stall_o), 64'd0);
        chk("rstmid_lo",    64'(b32.lo_o),    64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 4'd0, 32'd0, 32'd0, 1'b0); #1;
        chk("rstmid_idle_stall", 64'(b32.stall_o), 64'd0);
        chk("rstmid_idle_whilo", 64'(b32.whilo_o), 64'd0);
        @(posedge clk); #1;
        run_div32("divu_after_rst", 4'd13, 32'd100, 32'd7, 33, 32'd2, 32'd14);

        // Randomized single-cycle ops
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(1, 11);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            wr_in = 1'($urandom_range(0, 1));
            drive(1'b1, 4'(op), a, b, 1'b0);
            b32.wreg_i = wr_in; #1;
            model_single(op, a, b, wr_in, wd, wr, ovf, whilo, hi, lo);
            if (op <= 9) chk($sformatf("rnd%0d_op%0d_wdata", i, op), 64'(b32.wdata_o), 64'(wd));
            if (op >= 10) begin
                chk($sformatf("rnd%0d_op%0d_hi", i, op), 64'(b32.hi_o), 64'(hi));
                chk($sformatf("rnd%0d_op%0d_lo", i, op), 64'(b32.lo_o), 64'(lo));
            end
            chk($sformatf("rnd%0d_op%0d_wreg", i, op),  64'(b32.wreg_o),  64'(wr));
            chk($sformatf("rnd%0d_op%0d_ovf", i, op),   64'(b32.ovf_o),   64'(ovf));
            chk($sformatf("rnd%0d_op%0d_whilo", i, op), 64'(b32.whilo_o), 64'(whilo));
            chk($sformatf("rnd%0d_op%0d_stall", i, op), 64'(b32.stall_o), 64'd0);
            @(posedge clk); #1;
        end

        // Randomized divides
        for (int i = 0; i < 6; i++) begin
            op = $urandom_range(12, 13);
            a  = $urandom;
            b  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            if (op == 12 && $urandom_range(0, 1) != 0) b = -b;
            model_div(op == 12, 32, {32'd0, a}, {32'd0, b}, mhi, mlo);
            run_div32($sformatf("rnddiv%0d", i), 4'(op), a, b, 33, mhi[31:0], mlo[31:0]);
        end

        // 8-bit instance: most-negative / -1
        b8.valid_i = 1'b1; b8.op_i = 4'd12; b8.rdata1_i = 8'h80; b8.rdata2_i = 8'hFF;
        #1;
        n = 0;
        for (int i = 0; i < 32 && b8.stall_o === 1'b1; i++) begin
            n++;
            @(posedge clk); #2;
        end
        chk("w8_stalls", 64'(n), 64'd9);
        chk("w8_whilo",  64'(b8.whilo_o), 64'd1);
        chk("w8_lo",     64'(b8.lo_o),    64'h80);
        chk("w8_hi",     64'(b8.hi_o),    64'h00);
        @(posedge clk); #1;
        b8.valid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised execute stage for the openMips integer pipeline. It sits between the ID/EX and EX/MEM pipeline registers. It computes logic, add/sub, set-less-than and multiply results in a single cycle. Signed and unsigned division runs on an iterative radix-2 engine, and the block holds the pipeline with `stall_o` while that engine is busy. Multiply and divide results go to the HI/LO write port; all other results go to the GPR write port.

## Interface
- `DATA_W`, default 32: operand and result width; must be even and ≥4.
- `REG_ADDR_W`, default 5: destination register address width.
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: reset, synchronous, active-high.
- `valid_i  in  1`: the ID/EX register holds a live instruction.
- `op_i  in  4`: operation code.
  - 0 NOP, 1 OR, 2 AND, 3 XOR, 4 NOR, 5 ADD, 6 ADDU, 7 SUB, 8 SLT, 9 SLTU.
  - 10 MULT, 11 MULTU, 12 DIV, 13 DIVU.
  - 14–15 are treated as NOP.
- `rdata1_i`, `rdata2_i  in  DATA_W`: operands A and B.
- `rw_i  in  REG_ADDR_W`, `wreg_i  in  1`: GPR destination and write request.
- `cancel_i  in  1`: pipeline flush; aborts an in-flight divide.
- `rw_o  out  REG_ADDR_W`, `wreg_o  out  1`, `wdata_o  out  DATA_W`: GPR write port.
- `whilo_o  out  1`, `hi_o`, `lo_o  out  DATA_W`: HI/LO write port.
- `ovf_o  out  1`: signed overflow on ADD/SUB.
- `stall_o  out  1`: hold upstream stages.

## Operation
- **Output gating:**
  - All outputs are combinational from the inputs and internal state.
  - While `rst`=1 every output is 0.
  - While `valid_i`=0, `wreg_o`, `whilo_o`, `ovf_o` and `stall_o` are 0.
- **Single-cycle ops (1–11), GPR results:**
  - OR, AND, XOR, NOR, ADD, ADDU, SUB, SLT and SLTU drive `wdata_o`.
  - `rw_o`=`rw_i`, `wreg_o`=`wreg_i`.
- **ADD/SUB overflow:**
  - Two's-complement, modulo 2^DATA_W.
  - On signed overflow: `ovf_o`=1 and `wreg_o`=0.
  - ADDU never flags overflow.
- **SLT / SLTU:** `wdata_o` = {0…0, A<B}, signed for SLT, unsigned for SLTU.
- **MULT / MULTU:**
  - Full 2·DATA_W product, signed or unsigned.
  - `hi_o` = upper half, `lo_o` = lower half, `whilo_o`=1, `wreg_o`=0.
- **Divide FSM states:** IDLE, BUSY, DONE.
  - **IDLE → BUSY:** taken when `valid_i` and op is DIV/DIVU, with B≠0. The engine latches |A| and |B| (raw A and B for DIVU) plus sign flags, sets counter=0, and asserts `stall_o`.
  - **IDLE → DONE:** taken when B=0, with `stall_o` asserted. The result is quotient = all ones and remainder = A, unsigned, for both DIV and DIVU.
  - **BUSY:** restoring shift-subtract producing one quotient bit per cycle, for DATA_W cycles; `stall_o`=1. After the cycle with counter=DATA_W−1, go to DONE.
  - **DONE:** `stall_o`=0, `whilo_o`=1, `hi_o`=remainder, `lo_o`=quotient, `wreg_o`=0. Return to IDLE on the next edge.
- **DIV sign rules:**
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of A.
  - Most-negative ÷ −1: quotient = most-negative value, remainder = 0 (wraps, no flag).
- **Cancel:** `cancel_i`=1 in BUSY or DONE forces IDLE on the next edge. In the same cycle, `stall_o`, `whilo_o` and `wreg_o` are 0. In IDLE, `cancel_i` only gates outputs to 0 for that cycle.
- **Operand stability:** upstream holds `op_i` and the operands stable while `stall_o`=1. The engine uses only its latched copies after IDLE.

## Timing
- Single-cycle ops: zero-latency combinational path, `stall_o`=0.
- DIV/DIVU with B≠0:
  - Issued in cycle 0; `stall_o`=1 for cycles 0…DATA_W (DATA_W+1 cycles).
  - Result is presented in cycle DATA_W+1 with `stall_o`=0.
  - The pipeline advances at the end of cycle DATA_W+1.
- DIV/DIVU with B=0: `stall_o`=1 for cycle 0 only; result in cycle 1.
- In DONE, the block ignores `op_i`. A new divide is accepted only in IDLE, so there are no back-to-back restarts without DONE.
- `rst` asserted mid-divide: the FSM returns to IDLE at that edge and the latched operands are discarded.
- Reset state: FSM=IDLE, counter=0, engine registers=0.

## Test plan
- **Logic and arithmetic, DATA_W=32:**
  - OR 0x0000_F0F0 | 0x0F0F_0000 → `wdata_o`=0x0F0F_F0F0 with `wreg_o` following `wreg_i`.
  - ADD 0x7FFF_FFFF+1 → `ovf_o`=1, `wreg_o`=0.
  - ADDU of the same operands → 0x8000_0000 with `wreg_o`=1.
- **Compare and multiply:**
  - SLT −1 vs 1 → `wdata_o`=1; SLTU of the same operands → 0.
  - MULT −3×7 → `hi_o`=0xFFFF_FFFF, `lo_o`=0xFFFF_FFEB, `whilo_o`=1, no stall.
- **Signed divide:** DIV −7/2 → `stall_o` high for exactly 33 cycles, then `lo_o`=0xFFFF_FFFD and `hi_o`=0xFFFF_FFFF for one cycle with `whilo_o`=1.
  - DIVU 100/7 → `lo_o`=14, `hi_o`=2.
- **Divide by zero:** DIVU 5/0 → one stall cycle, then `lo_o`=0xFFFF_FFFF and `hi_o`=5.
- **Cancel and reset mid-divide:**
  - `cancel_i` at BUSY cycle 10 → `stall_o`=0 that cycle, no `whilo_o` pulse, FSM returns to IDLE.
  - A subsequent DIV gives the correct result.
  - Repeat the scenario using `rst` instead of `cancel_i`.
- **Parametrisation, DATA_W=8:** DIV −128/−1 → 9 stall cycles, `lo_o`=0x80, `hi_o`=0x00.
